regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read, dual-write register file for the RISC-V core, the successor to the fixed 2-read/1-write `regfile`. It adds:
- registered (synchronous) reads;
- a second writeback port, so the ALU and load unit can retire in the same cycle;
- a per-register busy scoreboard, so decode can detect RAW hazards against long-latency producers.

It sits between decode (read/reserve) and writeback.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥ 2)
- AW, 5, address width; must equal log2(NREG)
- NRD, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  registered read data, port i at [i*XLEN +: XLEN]
- rd_busy  out  NRD  registered busy flag of the addressed register
- wr0_en, wr1_en  in  1  write enables (wr0 = ALU, wr1 = load unit)
- wr0_addr, wr1_addr  in  AW  write addresses
- wr0_data, wr1_data  in  XLEN  write data
- wr0_clr, wr1_clr  in  1  write also clears the target's busy bit
- rsv_en  in  1  reserve (set busy) request
- rsv_addr  in  AW  register to reserve

## Operation
- Storage is NREG × XLEN flops plus an NREG-bit busy vector.
- Register 0:
  - writes to it are discarded;
  - rsv to it is ignored;
  - reads of it return data 0 and busy 0.
- Write priority: if wr0 and wr1 are enabled to the same nonzero address, wr1 data wins.
  - A busy clear is applied if either port's clr bit is set.
- Busy update, per register r at each edge:
  - set if rsv_en and rsv_addr == r;
  - else cleared if any enabled write port targets r with clr = 1;
  - else held.
  - Set beats clear on the same edge: a new reservation issued as the old producer retires stays busy.
- A write with clr = 0 updates data only and leaves busy unchanged.
- Read port i:
  - when rd_en[i] = 1 at an edge, rd_data/rd_busy for port i are loaded from rd_addr;
  - when rd_en[i] = 0, port i holds its previous outputs.
- Read ports are fully independent; any number may address the same register.
- No state machine beyond the storage, busy vector and output registers. All updates are single-edge.

## Timing
- Reset (asynchronous assert):
  - all registers 0;
  - all busy bits 0;
  - rd_data = 0, rd_busy = 0 on every port.
- Reset deassertion: first active edge is the first clk rising edge with rst low. Writes, reserves or reads presented at the same edge as a deasserting reset are not captured.
- Read latency:
  - address sampled at edge N; rd_data/rd_busy valid after edge N until the next enabled edge;
  - 1-cycle latency, versus combinational reads in `regfile`.
- Write latency: data stored at edge N; visible to reads sampled at edge N+1 in all builds.
- Same-edge write/read or rsv/read to the same address: the result depends on REGFILE_BYPASS_EN (see Configuration).
- Reset mid-operation overrides everything immediately, including pending reservations.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined — same-edge forwarding. A read sampled at edge N to address A returns:
  - the data written to A at edge N, with wr1 priority over wr0;
  - the busy value that A holds after edge N, including same-edge set/clear.
- Not defined — no forwarding. A read at edge N returns the pre-edge data and busy of A. Decode must then stall one extra cycle after a writeback. This build carries no comparator logic.
- Register 0 rules apply in both builds.

## Test plan
- Reset values: assert rst mid-run after writing x5 = 0x1234, then read x5 -> rd_data 0, rd_busy 0 on all ports; outputs are 0 during reset.
- Basic and x0 writes:
  - wr0 x1 = 0x00000FFF, then read x1 on port 0 next cycle -> 0x00000FFF one cycle after the address is sampled;
  - wr0 x0 = 0xDEAD, then read x0 -> 0.
- Dual-write collision: wr0 x3 = 0xAAAA and wr1 x3 = 0x5555 on one edge -> a later read of x3 returns 0x5555.
- Scoreboard:
  - rsv x7 -> the next read shows busy 1;
  - wr1 x7 = 0x42 with clr -> busy 0, data 0x42;
  - rsv x7 plus wr0 x7 with clr on the same edge -> busy remains 1;
  - rsv x0 -> busy stays 0.
- Same-edge bypass: wr0 x9 = 0x77 and read x9 on the same edge -> returns 0x77 with REGFILE_BYPASS_EN defined, and the prior value 0 without it. The following read returns 0x77 in both builds.
- Multi-port and hold (NRD = 3):
  - ports 0/1/2 read x1/x1/x2 together -> correct independent data;
  - drop rd_en[1] and change rd_addr[1] -> port 1 output holds its previous value.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with a per-register busy scoreboard and registered reads.
// Optional same-edge write/reserve forwarding to the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NRD-1:0]       rd_en_i,
    input  logic [NRD*AW-1:0]    rd_addr_i,
    output logic [NRD*XLEN-1:0]  rd_data_o,
    output logic [NRD-1:0]       rd_busy_o,
    input  logic                 wr0_en_i,
    input  logic [AW-1:0]        wr0_addr_i,
    input  logic [XLEN-1:0]      wr0_data_i,
    input  logic                 wr0_clr_i,
    input  logic                 wr1_en_i,
    input  logic [AW-1:0]        wr1_addr_i,
    input  logic [XLEN-1:0]      wr1_data_i,
    input  logic                 wr1_clr_i,
    input  logic                 rsv_en_i,
    input  logic [AW-1:0]        rsv_addr_i
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // wr1 is applied after wr0 so the load unit wins an address collision.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            mem_d[r] = mem_q[r];
            if (r != 0) begin
                if (wr0_en_i && wr0_addr_i == AW'(r)) mem_d[r] = wr0_data_i;
                if (wr1_en_i && wr1_addr_i == AW'(r)) mem_d[r] = wr1_data_i;
            end
        end
        mem_d[0] = '0;
    end

    // A reservation beats a retiring producer's clear on the same edge.
    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (rsv_en_i && rsv_addr_i == AW'(r))
                busy_d[r] = 1'b1;
            else if ((wr0_en_i && wr0_clr_i && wr0_addr_i == AW'(r)) ||
                     (wr1_en_i && wr1_clr_i && wr1_addr_i == AW'(r)))
                busy_d[r] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) mem_q[r] <= mem_d[r];
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data_d, data_q;
        logic            busy_rd_d, busy_rd_q;

        assign addr = rd_addr_i[i*AW +: AW];

        always_comb begin
            data_d    = data_q;
            busy_rd_d = busy_rd_q;
            if (rd_en_i[i]) begin
`ifdef REGFILE_BYPASS_EN
                data_d    = mem_d[addr];
                busy_rd_d = busy_d[addr];
`else
                data_d    = mem_q[addr];
                busy_rd_d = busy_q[addr];
`endif
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                data_q    <= '0;
                busy_rd_q <= 1'b0;
            end else begin
                data_q    <= data_d;
                busy_rd_q <= busy_rd_d;
            end
        end

        assign rd_data_o[i*XLEN +: XLEN] = data_q;
        assign rd_busy_o[i]              = busy_rd_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NRD = 3): directed scenarios plus randomized traffic
// compared every cycle against an array-based model of the register file.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr0_en, wr0_clr, wr1_en, wr1_clr, rsv_en;
    logic [AW-1:0]       wr0_addr, wr1_addr, rsv_addr;
    logic [XLEN-1:0]     wr0_data, wr1_data;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD)) dut (
        .clk_i(clk), .rst_i(rst),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data), .wr0_clr_i(wr0_clr),
        .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data), .wr1_clr_i(wr1_clr),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [XLEN-1:0] m_mem  [NREG];
    logic            m_busy [NREG];
    logic [XLEN-1:0] e_data [NRD];
    logic            e_busy [NRD];

    task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
        for (int i = 0; i < NRD; i++) begin
            e_data[i] = '0;
            e_busy[i] = 1'b0;
        end
    endtask

    // Architectural view: apply the edge's writes/clears/reserve, then serve reads
    // from either the old or the new state.
    task automatic model_edge();
        logic [XLEN-1:0] old_mem  [NREG];
        logic            old_busy [NREG];
        int a;
        for (int r = 0; r < NREG; r++) begin
            old_mem[r]  = m_mem[r];
            old_busy[r] = m_busy[r];
        end
        if (wr0_en) m_mem[wr0_addr] = wr0_data;
        if (wr1_en) m_mem[wr1_addr] = wr1_data;
        if (wr0_en && wr0_clr) m_busy[wr0_addr] = 1'b0;
        if (wr1_en && wr1_clr) m_busy[wr1_addr] = 1'b0;
        if (rsv_en) m_busy[rsv_addr] = 1'b1;
        m_mem[0]  = '0;
        m_busy[0] = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            if (rd_en[i]) begin
                a = int'(rd_addr[i*AW +: AW]);
`ifdef REGFILE_BYPASS_EN
                e_data[i] = m_mem[a];
                e_busy[i] = m_busy[a];
`else
                e_data[i] = old_mem[a];
                e_busy[i] = old_busy[a];
`endif
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NRD; i++) begin
            check($sformatf("model_data[%0d]", i), rd_data[i*XLEN +: XLEN], e_data[i]);
            check($sformatf("model_busy[%0d]", i), {31'd0, rd_busy[i]}, {31'd0, e_busy[i]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        rd_en = '0; wr0_en = 0; wr1_en = 0; wr0_clr = 0; wr1_clr = 0; rsv_en = 0;
    endtask

    task automatic rd(input int port, input int addr);
        rd_en[port] = 1'b1;
        rd_addr[port*AW +: AW] = AW'(addr);
    endtask

    task automatic wr0(input int addr, input logic [XLEN-1:0] d, input logic clr);
        wr0_en = 1; wr0_addr = AW'(addr); wr0_data = d; wr0_clr = clr;
    endtask

    task automatic wr1(input int addr, input logic [XLEN-1:0] d, input logic clr);
        wr1_en = 1; wr1_addr = AW'(addr); wr1_data = d; wr1_clr = clr;
    endtask

    task automatic rsv(input int addr);
        rsv_en = 1; rsv_addr = AW'(addr);
    endtask

    initial begin
        rst = 1; rd_addr = '0; wr0_addr = '0; wr1_addr = '0; rsv_addr = '0;
        wr0_data = '0; wr1_data = '0;
        idle();
        model_reset();
        tick(); tick();
        rst = 0;
        check("reset_data0", rd_data[0 +: XLEN], 32'h0);

        // mid-run reset wipes a written register
        wr0(5, 32'h1234, 0); tick(); idle();
        rd(0, 5); tick(); idle();
        check("x5_before_rst", rd_data[0 +: XLEN], 32'h1234);
        #2 rst = 1;
        #1;
        model_reset();
        check("rst_async_data0", rd_data[0 +: XLEN], 32'h0);
        tick();
        rst = 0;
        rd(0, 5); rd(1, 5); rd(2, 5); tick(); idle();
        for (int i = 0; i < NRD; i++) begin
            check("x5_after_rst", rd_data[i*XLEN +: XLEN], 32'h0);
            check("x5_busy_after_rst", {31'd0, rd_busy[i]}, 32'h0);
        end

        wr0(1, 32'h0000_0FFF, 0); tick(); idle();
        rd(0, 1); tick(); idle();
        check("x1_read", rd_data[0 +: XLEN], 32'h0000_0FFF);

        wr0(0, 32'hDEAD, 0); tick(); idle();
        rd(0, 0); tick(); idle();
        check("x0_read", rd_data[0 +: XLEN], 32'h0);

        wr0(3, 32'hAAAA, 0); wr1(3, 32'h5555, 0); tick(); idle();
        rd(0, 3); tick(); idle();
        check("collision_x3", rd_data[0 +: XLEN], 32'h5555);

        rsv(7); tick(); idle();
        rd(0, 7); tick(); idle();
        check("rsv_x7_busy", {31'd0, rd_busy[0]}, 32'h1);
        wr1(7, 32'h42, 1); tick(); idle();
        rd(0, 7); tick(); idle();
        check("clr_x7_busy", {31'd0, rd_busy[0]}, 32'h0);
        check("clr_x7_data", rd_data[0 +: XLEN], 32'h42);
        rsv(7); wr0(7, 32'h43, 1); tick(); idle();
        rd(0, 7); tick(); idle();
        check("set_beats_clr", {31'd0, rd_busy[0]}, 32'h1);
        rsv(0); tick(); idle();
        rd(0, 0); tick(); idle();
        check("rsv_x0_busy", {31'd0, rd_busy[0]}, 32'h0);

        wr0(9, 32'h77, 0); rd(0, 9); tick(); idle();
`ifdef REGFILE_BYPASS_EN
        check("bypass_x9", rd_data[0 +: XLEN], 32'h77);
`else
        check("nobypass_x9", rd_data[0 +: XLEN], 32'h0);
`endif
        rd(0, 9); tick(); idle();
        check("x9_next", rd_data[0 +: XLEN], 32'h77);

        wr0(2, 32'hBEEF, 0); tick(); idle();
        rd(0, 1); rd(1, 1); rd(2, 2); tick(); idle();
        check("mp_port0", rd_data[0*XLEN +: XLEN], 32'h0FFF);
        check("mp_port1", rd_data[1*XLEN +: XLEN], 32'h0FFF);
        check("mp_port2", rd_data[2*XLEN +: XLEN], 32'hBEEF);
        rd(0, 3); rd(2, 3); rd_addr[1*AW +: AW] = AW'(3); rd_en[1] = 0; tick(); idle();
        check("hold_port1", rd_data[1*XLEN +: XLEN], 32'h0FFF);
        check("mp_port0_x3", rd_data[0*XLEN +: XLEN], 32'h5555);

        for (int c = 0; c < 400; c++) begin
            rd_en    = NRD'($urandom);
            rd_addr  = (NRD*AW)'({$urandom, $urandom});
            for (int i = 0; i < NRD; i++)
                if ($urandom_range(0, 1) == 1) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
            wr0_en   = ($urandom_range(0, 2) != 0);
            wr0_addr = AW'($urandom_range(0, 7));
            wr0_data = $urandom;
            wr0_clr  = $urandom_range(0, 1) == 1;
            wr1_en   = ($urandom_range(0, 2) != 0);
            wr1_addr = AW'($urandom_range(0, 7));
            wr1_data = $urandom;
            wr1_clr  = $urandom_range(0, 1) == 1;
            rsv_en   = ($urandom_range(0, 1) == 1);
            rsv_addr = AW'($urandom_range(0, 7));
            rst      = (c == 200);
            tick();
        end
        rst = 0;
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
